// File: rtl/bc_pkg.sv
// Shared Bulls and Cows constants and types.
// Used by the keypad entry, game-logic and display stages.
package bc_pkg;
    localparam logic [3:0] EMPTY_NIBBLE = 4'hF;
    localparam int NUM_DIGITS = 4;
    localparam int NUM_KEYS = 10;

    typedef enum logic [1:0] {
        EMPTY,
        COLLECT,
        FULL
    } entry_state_t;
endpackage

// File: rtl/guess_entry_if.sv
// Keypad entry bundle: raw keys and clear in, assembled guess out
// over a valid/ready handshake towards the game logic.
interface guess_entry_if;
    import bc_pkg::*;

    logic [NUM_KEYS-1:0] key;
    logic                clear;
    logic                guess_ready;
    logic [15:0]         entry;
    logic [2:0]          digit_count;
    logic                guess_valid;
    logic                dup_err;
    logic [6:0]          attempts;

    modport master (
        input  key,
        input  clear,
        input  guess_ready,
        output entry,
        output digit_count,
        output guess_valid,
        output dup_err,
        output attempts
    );

    modport slave (
        output key,
        output clear,
        output guess_ready,
        input  entry,
        input  digit_count,
        input  guess_valid,
        input  dup_err,
        input  attempts
    );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus restart-on-change debouncer.
// Emits a one-cycle press when the vector goes from zero to one-hot.
module key_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key,
    output logic [WIDTH-1:0] deb,
    output logic             press,
    output logic [3:0]       digit
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] deb_d;
    logic [CW-1:0]    cnt;
    logic [3:0]       enc;

    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (deb[i]) enc = 4'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            deb   <= '0;
            deb_d <= '0;
            cnt   <= '0;
            press <= 1'b0;
            digit <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            deb_d <= deb;
            press <= $onehot(deb) && (deb_d == '0);
            digit <= enc;
            // cnt = clocks the candidate value has been held so far
            if (sync2 == deb) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CW'(1);
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/guess_entry.sv
// Keypad front end: collects four distinct digits into a guess
// and offers it to the game logic over valid/ready.
module guess_entry
    import bc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit ALLOW_DUP       = 1'b0
) (
    input logic         clk,
    input logic         rst,
    guess_entry_if.master bus
);
    entry_state_t         state;
    logic [3:0]           slot [NUM_DIGITS];
    logic [2:0]           cnt_q;
    logic                 valid_q;
    logic                 dup_q;
    logic [6:0]           att_q;
    logic [NUM_KEYS-1:0]  deb;
    logic                 press;
    logic [3:0]           digit;
    logic                 dup;
    logic                 xfer;
    logic                 accept;

    key_debounce #(
        .WIDTH          (NUM_KEYS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk  (clk),
        .rst  (rst),
        .key  (bus.key),
        .deb  (deb),
        .press(press),
        .digit(digit)
    );

    assign xfer   = valid_q && bus.guess_ready;
    assign accept = press && $onehot(deb);

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) < cnt_q && slot[i] == digit) dup = 1'b1;
        end
        if (ALLOW_DUP) dup = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dup_q   <= 1'b0;
            att_q   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) slot[i] <= EMPTY_NIBBLE;
        end else begin
            dup_q <= 1'b0;
            if (xfer && att_q != 7'h7F) att_q <= att_q + 7'd1;
            // clear and a completed transfer both discard any same-cycle press
            if (bus.clear || xfer) begin
                state   <= EMPTY;
                cnt_q   <= '0;
                valid_q <= 1'b0;
                for (int i = 0; i < NUM_DIGITS; i++) slot[i] <= EMPTY_NIBBLE;
            end else begin
                unique case (state)
                    EMPTY, COLLECT: begin
                        if (accept && dup) begin
                            dup_q <= 1'b1;
                        end else if (accept) begin
                            slot[cnt_q[1:0]] <= digit;
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'(NUM_DIGITS - 1)) begin
                                state   <= FULL;
                                valid_q <= 1'b1;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                    FULL: ;
                    default: state <= EMPTY;
                endcase
            end
        end
    end

    assign bus.entry       = {slot[0], slot[1], slot[2], slot[3]};
    assign bus.digit_count = cnt_q;
    assign bus.guess_valid = valid_q;
    assign bus.dup_err     = dup_q;
    assign bus.attempts    = att_q;
endmodule

// File: tb/tb_guess_entry.sv
// Self-checking bench for guess_entry with a short debounce window.
// A second instance runs with duplicate rejection disabled.
module tb_guess_entry;
    localparam int D = 4;

    typedef struct {
        logic [15:0] e;
        logic [2:0]  c;
        logic        dup;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key;
    logic       clear;
    logic       ready_a;
    logic       ready_b;
    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];

    guess_entry_if ifa ();
    guess_entry_if ifb ();

    assign ifa.key         = key;
    assign ifa.clear       = clear;
    assign ifa.guess_ready = ready_a;
    assign ifb.key         = key;
    assign ifb.clear       = clear;
    assign ifb.guess_ready = ready_b;

    guess_entry #(.DEBOUNCE_CYCLES(D), .ALLOW_DUP(1'b0)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(ifa)
    );

    guess_entry #(.DEBOUNCE_CYCLES(D), .ALLOW_DUP(1'b1)) u_dup (
        .clk(clk),
        .rst(rst),
        .bus(ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic press_digit(input int d, input logic [15:0] ee,
                               input logic [2:0] ec, input logic ed,
                               input string nm);
        exp_t x;
        logic [2:0] c0;
        bit hit;
        int lat;
        x.e = ee;
        x.c = ec;
        x.dup = ed;
        sb.push_back(x);
        c0 = ifa.digit_count;
        hit = 0;
        lat = -1;
        @(negedge clk);
        key[d] = 1'b1;
        for (int i = 0; i < D + 12; i++) begin
            @(posedge clk);
            #1;
            if (ifa.dup_err || ifa.digit_count != c0) begin
                hit = 1;
                lat = i;
                break;
            end
        end
        x = sb.pop_front();
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s timeout: no store/dup_err in %0d cycles", nm, D + 12);
        end else begin
            checks++;
            if (lat != D + 3) begin
                errors++;
                $display("FAIL %s latency: got edge %0d want %0d", nm, lat, D + 3);
            end
            checks++;
            if (ifa.entry !== x.e) begin
                errors++;
                $display("FAIL %s entry: got %h want %h", nm, ifa.entry, x.e);
            end
            checks++;
            if (ifa.digit_count !== x.c) begin
                errors++;
                $display("FAIL %s count: got %0d want %0d", nm, ifa.digit_count, x.c);
            end
            checks++;
            if (ifa.dup_err !== x.dup) begin
                errors++;
                $display("FAIL %s dup_err: got %b want %b", nm, ifa.dup_err, x.dup);
            end
        end
        @(negedge clk);
        key[d] = 1'b0;
        repeat (D + 6) @(posedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key = '0;
        clear = 1'b0;
        ready_a = 1'b0;
        ready_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifa.entry !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset entry: got %h want ffff", ifa.entry);
        end
        checks++;
        if (ifa.digit_count !== 3'd0 || ifa.guess_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset count/valid: got %0d/%b want 0/0",
                     ifa.digit_count, ifa.guess_valid);
        end
        checks++;
        if (ifa.dup_err !== 1'b0 || ifa.attempts !== 7'd0) begin
            errors++;
            $display("FAIL reset dup/attempts: got %b/%0d want 0/0",
                     ifa.dup_err, ifa.attempts);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_guess();
        press_digit(1, 16'h1FFF, 3'd1, 1'b0, "g1");
        press_digit(2, 16'h12FF, 3'd2, 1'b0, "g2");
        press_digit(3, 16'h123F, 3'd3, 1'b0, "g3");
        press_digit(4, 16'h1234, 3'd4, 1'b0, "g4");
        checks++;
        if (ifa.guess_valid !== 1'b1 || ifa.entry !== 16'h1234) begin
            errors++;
            $display("FAIL full hold: valid=%b entry=%h want 1/1234",
                     ifa.guess_valid, ifa.entry);
        end
        @(negedge clk);
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ifa.guess_valid !== 1'b0 || ifa.entry !== 16'hFFFF) begin
            errors++;
            $display("FAIL handshake: valid=%b entry=%h want 0/ffff",
                     ifa.guess_valid, ifa.entry);
        end
        checks++;
        if (ifa.attempts !== 7'd1 || ifa.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL handshake attempts/count: got %0d/%0d want 1/0",
                     ifa.attempts, ifa.digit_count);
        end
        @(negedge clk);
        ready_a = 1'b0;
    endtask

    task automatic test_bounce();
        do_clear();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            key[5] = ~key[5];
            @(negedge clk);
        end
        repeat (D + 4) @(posedge clk);
        #1;
        checks++;
        if (ifa.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL bounce spurious: count=%0d want 0", ifa.digit_count);
        end
        press_digit(5, 16'h5FFF, 3'd1, 1'b0, "bounce");
    endtask

    task automatic test_dup();
        do_clear();
        press_digit(7, 16'h7FFF, 3'd1, 1'b0, "dup1");
        press_digit(7, 16'h7FFF, 3'd1, 1'b1, "dup2");
        #1;
        checks++;
        if (ifa.dup_err !== 1'b0) begin
            errors++;
            $display("FAIL dup pulse width: dup_err=%b want 0", ifa.dup_err);
        end
        checks++;
        if (ifb.entry !== 16'h77FF || ifb.digit_count !== 3'd2) begin
            errors++;
            $display("FAIL allow_dup: entry=%h count=%0d want 77ff/2",
                     ifb.entry, ifb.digit_count);
        end
    endtask

    task automatic test_multikey();
        do_clear();
        @(negedge clk);
        key[2] = 1'b1;
        key[3] = 1'b1;
        repeat (D + 10) @(posedge clk);
        #1;
        checks++;
        if (ifa.digit_count !== 3'd0 || ifa.entry !== 16'hFFFF) begin
            errors++;
            $display("FAIL multikey: count=%0d entry=%h want 0/ffff",
                     ifa.digit_count, ifa.entry);
        end
        @(negedge clk);
        key[2] = 1'b0;
        key[3] = 1'b0;
        repeat (D + 6) @(posedge clk);
        press_digit(3, 16'h3FFF, 3'd1, 1'b0, "after_multi");
    endtask

    task automatic test_clear_handshake();
        do_clear();
        press_digit(9, 16'h9FFF, 3'd1, 1'b0, "c9");
        press_digit(8, 16'h98FF, 3'd2, 1'b0, "c8");
        press_digit(7, 16'h987F, 3'd3, 1'b0, "c7");
        press_digit(6, 16'h9876, 3'd4, 1'b0, "c6");
        @(negedge clk);
        key[5] = 1'b1;
        repeat (D + 8) @(posedge clk);
        #1;
        checks++;
        if (ifa.entry !== 16'h9876 || ifa.guess_valid !== 1'b1) begin
            errors++;
            $display("FAIL full ignores press: entry=%h valid=%b want 9876/1",
                     ifa.entry, ifa.guess_valid);
        end
        @(negedge clk);
        key[5] = 1'b0;
        repeat (D + 6) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ifa.attempts !== 7'd2 || ifa.entry !== 16'hFFFF || ifa.guess_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear+xfer: attempts=%0d entry=%h valid=%b want 2/ffff/0",
                     ifa.attempts, ifa.entry, ifa.guess_valid);
        end
        @(negedge clk);
        clear = 1'b0;
        ready_a = 1'b0;
    endtask

    task automatic test_clear_press();
        do_clear();
        @(negedge clk);
        key[4] = 1'b1;
        repeat (D + 3) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ifa.digit_count !== 3'd0 || ifa.entry !== 16'hFFFF || ifa.dup_err !== 1'b0) begin
            errors++;
            $display("FAIL clear+press: count=%0d entry=%h dup=%b want 0/ffff/0",
                     ifa.digit_count, ifa.entry, ifa.dup_err);
        end
        @(negedge clk);
        clear = 1'b0;
        key[4] = 1'b0;
        repeat (D + 6) @(posedge clk);
        #1;
        checks++;
        if (ifa.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL clear+press late store: count=%0d want 0", ifa.digit_count);
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        press_digit(1, 16'h1FFF, 3'd1, 1'b0, "r1");
        press_digit(2, 16'h12FF, 3'd2, 1'b0, "r2");
        @(negedge clk);
        key[5] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ifa.entry !== 16'hFFFF || ifa.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL async reset entry/count: %h/%0d want ffff/0",
                     ifa.entry, ifa.digit_count);
        end
        checks++;
        if (ifa.attempts !== 7'd0 || ifa.guess_valid !== 1'b0 || ifa.dup_err !== 1'b0) begin
            errors++;
            $display("FAIL async reset attempts/valid/dup: %0d/%b/%b want 0/0/0",
                     ifa.attempts, ifa.guess_valid, ifa.dup_err);
        end
        key[5] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (D + 6) @(posedge clk);
        #1;
        checks++;
        if (ifa.digit_count !== 3'd0) begin
            errors++;
            $display("FAIL in-flight press survived reset: count=%0d want 0",
                     ifa.digit_count);
        end
        press_digit(6, 16'h6FFF, 3'd1, 1'b0, "post_rst");
    endtask

    initial begin
        test_reset();
        test_full_guess();
        test_bounce();
        test_dup();
        test_multikey();
        test_clear_handshake();
        test_clear_press();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
